// File: rtl/apb_uart_requester.sv
// apb_uart_requester: valid/ready command stream to single APB SETUP/ACCESS transfers with a valid/ready response.
// Optional ACCESS timeout enabled by defining APB_REQ_TIMEOUT_EN.
module apb_uart_requester #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              resp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic write_q, write_d, err_q, err_d, legal, expire;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  // Register map spans 0x000..0x020 in word steps
  assign legal = cmd_addr <= ADDR_W'(32) && cmd_addr[1:0] == 2'b00;
`ifdef APB_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic tmo_q, tmo_d;
  assign expire = cnt_q == CNT_W'(TIMEOUT_CYC - 1);
  always_comb begin
    cnt_d = state_q == ACCESS && !pready ? cnt_q + 1'b1 : '0;
    tmo_d = state_q == IDLE ? 1'b0 : (state_q == ACCESS && !pready && expire) ? 1'b1 : tmo_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign resp_timeout = tmo_q;
`else
  assign expire = 1'b0;
  assign resp_timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        write_d = cmd_write;
        addr_d = cmd_addr;
        wdata_d = cmd_wdata;
        rdata_d = '0;
        err_d = !legal;
        state_d = legal ? SETUP : RESP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (pready) begin
        rdata_d = write_q ? '0 : prdata;
        err_d = pslverr;
        state_d = RESP;
      end else if (expire) begin
        rdata_d = '0;
        err_d = 1'b1;
        state_d = RESP;
      end
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign psel = state_q == SETUP || state_q == ACCESS;
  assign penable = state_q == ACCESS;
  assign resp_valid = state_q == RESP;
  assign pwrite = write_q;
  assign paddr = addr_q;
  assign pwdata = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
endmodule

// File: tb/tb_apb_uart_requester.sv
// tb_apb_uart_requester: randomized bench with a transaction-timeline model of apb_uart_requester.
module tb_apb_uart_requester;
  localparam int TIMEOUT_CYC = 16;
  logic clk = 0, rst = 1;
  logic cmd_valid, cmd_ready, cmd_write, resp_valid, resp_ready, resp_err, resp_timeout;
  logic psel, penable, pwrite, pready, pslverr;
  logic [11:0] cmd_addr, paddr;
  logic [31:0] cmd_wdata, resp_rdata, pwdata, prdata;

  apb_uart_requester #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .resp_timeout(resp_timeout), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wr;
    logic [11:0] a;
    logic [31:0] d;
    int w;
    logic perr;
    logic [31:0] pr;
    int hr;
  } cmd_t;

  cmd_t cq[$];
  cmd_t c_m;
  int ecount = 0, k_m = 0, rs_m = 0;
  logic act_m = 0, leg_m = 0, tm_m = 0;
  int total = 0, bad = 0;
  int n_psel = 0, n_pen = 0, n_rv = 0, first_rv = -1, last_k = -1;
  logic [31:0] lr_rdata = 0;
  logic lr_err = 0, lr_tmo = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, ecount);
    end
  endtask

  function automatic logic legal_f(logic [11:0] a);
    return a <= 12'h020 && a % 4 == 0;
  endfunction

  function automatic logic tmo_f(int w);
`ifdef APB_REQ_TIMEOUT_EN
    return w >= TIMEOUT_CYC;
`else
    return 1'b0;
`endif
  endfunction

  // Model: a transaction occupies a timeline measured in edges since acceptance.
  // Legal: SETUP at rel 0, ACCESS rel 1..rs_m-1, response from rel rs_m. Illegal: response at rel 0.
  always @(posedge clk) begin
    ecount <= ecount + 1;
    if (rst) act_m <= 1'b0;
    else if (!act_m) begin
      if (cmd_valid && cq.size() > 0) begin
        c_m <= cq[0];
        leg_m <= legal_f(cq[0].a);
        tm_m <= legal_f(cq[0].a) && tmo_f(cq[0].w);
        rs_m <= !legal_f(cq[0].a) ? 0 : tmo_f(cq[0].w) ? 1 + TIMEOUT_CYC : 2 + cq[0].w;
        k_m <= ecount + 1;
        act_m <= 1'b1;
        cq.pop_front();
      end
    end else if (ecount - k_m >= rs_m && resp_ready) act_m <= 1'b0;
  end

  // Driver: command pins, APB completer behaviour and response consumer, all from the model timeline
  initial begin
    int rel;
    logic fin;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    resp_ready = 0; prdata = 0; pready = 0; pslverr = 0;
    forever begin
      @(negedge clk);
      rel = ecount - k_m;
      if (act_m && leg_m && rel >= 1 && rel < rs_m) begin
        fin = rel == rs_m - 1 && !tm_m;
        pready = fin;
        pslverr = fin ? c_m.perr : 1'($urandom);
        prdata = fin ? c_m.pr : $urandom;
      end else begin
        pready = 1'($urandom);
        pslverr = 1'($urandom);
        prdata = $urandom;
      end
      resp_ready = (act_m && rel >= rs_m) ? (rel >= rs_m + c_m.hr) : 1'($urandom);
      if (!act_m && cq.size() > 0) begin
        cmd_valid = $urandom_range(0, 3) != 0;
        cmd_write = cq[0].wr;
        cmd_addr = cq[0].a;
        cmd_wdata = cq[0].d;
      end else begin
        cmd_valid = act_m ? 1'($urandom) : 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr = 12'($urandom);
        cmd_wdata = $urandom;
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the model timeline
  initial begin
    int r;
    logic ep, ee, ev;
    forever begin
      @(negedge clk);
      if (ecount > 0) begin
        r = ecount - k_m;
        ep = act_m && leg_m && r < rs_m;
        ee = ep && r >= 1;
        ev = act_m && r >= rs_m;
        if (k_m != last_k) begin
          last_k = k_m; n_psel = 0; n_pen = 0; n_rv = 0; first_rv = -1;
        end
        chk("cmd_ready", cmd_ready, !act_m);
        chk("psel", psel, ep);
        chk("penable", penable, ee);
        chk("resp_valid", resp_valid, ev);
        if (ep) begin
          chk("paddr", paddr, c_m.a);
          chk("pwrite", pwrite, c_m.wr);
          chk("pwdata", pwdata, c_m.d);
        end
        if (ev) begin
          chk("resp_rdata", resp_rdata, (!leg_m || tm_m || c_m.wr) ? 32'h0 : c_m.pr);
          chk("resp_err", resp_err, !leg_m || tm_m || c_m.perr);
          chk("resp_timeout", resp_timeout, tm_m);
        end
        n_psel += psel;
        n_pen += penable;
        n_rv += resp_valid;
        if (resp_valid && first_rv < 0) first_rv = r;
        if (resp_valid) begin
          lr_rdata = resp_rdata; lr_err = resp_err; lr_tmo = resp_timeout;
        end
      end
    end
  end

  task automatic push(logic wr, logic [11:0] a, logic [31:0] d, int w, logic perr, logic [31:0] pr, int hr);
    cmd_t c;
    c.wr = wr; c.a = a; c.d = d; c.w = w; c.perr = perr; c.pr = pr; c.hr = hr;
    cq.push_back(c);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while ((act_m || cq.size() > 0) && n < 3000);
    if (n >= 3000) chk("wait_idle_expired", 1, 0);
  endtask

  initial begin
    int n;
    rst = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_paddr", paddr, 0);
    rst = 0;
    push(1, 12'h008, 32'h3, 0, 0, 32'hdeadbeef, 0);
    wait_idle();
    chk("lcr_latency", first_rv, 2);
    chk("lcr_psel_cycles", n_psel, 2);
    chk("lcr_pen_cycles", n_pen, 1);
    chk("lcr_rdata", lr_rdata, 0);
    chk("lcr_err", lr_err, 0);
    push(0, 12'h010, 32'h0, 3, 0, 32'h60, 1);
    wait_idle();
    chk("lsr_latency", first_rv, 5);
    chk("lsr_pen_cycles", n_pen, 4);
    chk("lsr_rdata", lr_rdata, 32'h60);
    push(0, 12'h006, 32'h0, 0, 0, 32'h11, 0);
    wait_idle();
    chk("misalign_latency", first_rv, 0);
    chk("misalign_psel", n_psel, 0);
    chk("misalign_err", lr_err, 1);
    chk("misalign_rdata", lr_rdata, 0);
    push(0, 12'h024, 32'h0, 0, 0, 32'h22, 0);
    wait_idle();
    chk("unmapped_latency", first_rv, 0);
    chk("unmapped_psel", n_psel, 0);
    chk("unmapped_err", lr_err, 1);
    chk("unmapped_rdata", lr_rdata, 0);
    push(1, 12'h018, 32'h5, 0, 1, 32'h0, 5);
    wait_idle();
    chk("ier_err", lr_err, 1);
    chk("ier_timeout", lr_tmo, 0);
    chk("ier_resp_cycles", n_rv, 6);
    push(0, 12'h004, 32'h0, 10, 0, 32'h77, 0);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(act_m && ecount - k_m == 2) && n < 100);
    if (n >= 100) chk("rdr_access_expired", 1, 0);
    rst = 1;
    @(posedge clk);
    #2;
    rst = 0;
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    push(1, 12'h000, 32'h41, 1, 0, 32'h0, 0);
    wait_idle();
    chk("tdr_latency", first_rv, 3);
    chk("tdr_err", lr_err, 0);
    push(0, 12'h00c, 32'h0, 120, 0, 32'h5a, 0);
    wait_idle();
`ifdef APB_REQ_TIMEOUT_EN
    chk("long_pen_cycles", n_pen, TIMEOUT_CYC);
    chk("long_err", lr_err, 1);
    chk("long_timeout", lr_tmo, 1);
    chk("long_rdata", lr_rdata, 0);
`else
    chk("long_pen_cycles", n_pen, 121);
    chk("long_timeout", lr_tmo, 0);
    chk("long_rdata", lr_rdata, 32'h5a);
`endif
    for (int i = 0; i < 60; i++) begin
      logic [11:0] a;
      a = ($urandom_range(0, 9) < 7) ? 12'($urandom_range(0, 8) * 4) : 12'($urandom_range(0, 63));
      push(1'($urandom), a, $urandom, $urandom_range(0, 4), 1'($urandom_range(0, 3) == 0),
           $urandom, $urandom_range(0, 3));
    end
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
